microwave_timer_ctrl: RTL and testbench
=======================================

Name: microwave_timer_ctrl

Overview:
Sequencer for the cascaded down-counting timer digits (minutes, seconds-tens, seconds-ones) of the microwave.
- Collects keypad digits.
- Loads the digit counters.
- Generates the 1 s count-enable tick.
- Handles start/stop/door events.
- Drives the magnetron and end-of-cook indication.
It sits between the keypad decoder and the timer counter chain.

Parameters:
TICK_DIV, 50000000, clock cycles per countdown tick (1 s); minimum 2
BEEP_CYCLES, 25000000, length of the done beep in cycles (used only with the optional feature)

Ports:
clock  input  1  system clock; all logic on rising edge
clear  input  1  asynchronous, active-high reset
key_valid  input  1  single-cycle strobe: key_digit is valid
key_digit  input  4  keypad digit; values above 9 are ignored
start  input  1  single-cycle start request
stop  input  1  single-cycle stop/cancel request
door_closed  input  1  1 = door closed
cnt_zero  input  3  zero flags from the counters {min, sec_tens, sec_ones}
loadn  output  1  active-low load strobe to all counters
enable  output  1  count-enable pulse to the seconds-ones counter
entry  output  12  entered time {min, sec_tens, sec_ones}; drives the counter data_in
mag_on  output  1  magnetron enable
done  output  1  cooking finished
state_out  output  3  current state encoding (debug)

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, loadn=1, enable=0, mag_on=0, done=0, entry=0, prescaler=0.
- clear acts immediately at any time, including mid-RUN, and returns the block to reset values.
- State encodings: IDLE=0, ENTRY=1, LOAD=2, RUN=3, PAUSE=4, DONE=5; codes 6 and 7 go to IDLE on the next clock.
- Priority when inputs coincide: clear > stop > door open > start > key_valid.
- IDLE:
  - A valid key (≤9) shifts in: entry <= {entry[7:0], key_digit}; go to ENTRY.
  - A key >9 is ignored.
- ENTRY:
  - Valid keys keep shifting; the oldest digit falls off.
  - stop: entry=0, go to IDLE.
  - start is accepted only if all hold: door_closed=1, entry≠0, entry[7:4]≤5. Otherwise it is ignored and the state is held.
  - An accepted start goes to LOAD.
- LOAD:
  - Lasts exactly one cycle with loadn=0; the prescaler clears to 0.
  - Next state is RUN.
  - Latency: start sampled at edge N gives loadn=0 during cycle N+1 and RUN from edge N+2.
- RUN:
  - mag_on=1; the prescaler counts 0..TICK_DIV-1 and wraps.
  - In the wrap cycle: if cnt_zero==3'b111, go to DONE with no enable pulse; otherwise enable=1 for exactly one cycle.
  - The first enable arrives TICK_DIV cycles after entering RUN.
  - stop or door_closed=0 goes to PAUSE; mag_on drops on the same edge.
  - key_valid is ignored in RUN.
- PAUSE:
  - mag_on=0; the prescaler value is held.
  - start with door_closed=1 returns to RUN and the prescaler resumes from its held value.
  - stop: entry=0, go to IDLE.
- DONE:
  - done=1, mag_on=0.
  - Any of start, stop or key_valid clears done, sets entry=0 and goes to IDLE; the event is not otherwise acted on.
- enable and loadn are never active in the same cycle.
- Outside RUN, enable=0. Outside LOAD, loadn=1.

Optional Feature:
MICROWAVE_CTRL_BEEP_EN
- Defined:
  - Adds output port beep (1 bit, reset 0).
  - On entry to DONE, beep=1 and a counter runs for BEEP_CYCLES cycles.
  - When the counter expires: beep=0, done=0, entry=0, state goes to IDLE automatically.
  - start, stop or key_valid during the beep terminates it early with the same result.
- Undefined: there is no beep port, and DONE is held until start, stop or key_valid.

Test Plan:
Run with TICK_DIV=4 and BEEP_CYCLES=6.
1. Key entry: keys 1, 3, 0 → entry=0x130. Then key 0xA → entry unchanged. Then key 5 → entry=0x305 (oldest digit dropped).
2. Start: entry=0x012, door_closed=1, start pulse → loadn=0 for exactly one cycle. Then RUN with mag_on=1, and enable pulses every 4th cycle with the first one 4 cycles after RUN entry.
3. Run to completion: model counters counting 0x002 to 0x000 → the wrap with cnt_zero=111 produces no enable. The next edge gives done=1, mag_on=0. With the macro: beep=1 for 6 cycles, then IDLE with done=0.
4. Pause/resume: door_closed goes 0 mid-RUN at prescaler=2 → PAUSE, mag_on=0 next edge. Close the door and start → RUN; the next enable comes after 2 cycles.
5. Rejected starts: entry=0x070 + start → stays ENTRY. entry=0 + start → stays IDLE. Door open + start → no LOAD.
6. Priority and reset: start and stop in the same cycle while in ENTRY → IDLE with entry=0. clear asserted mid-RUN → immediately mag_on=0, enable=0, state_out=0.

Source files
------------

// File: rtl/microwave_timer_ctrl.sv
// Microwave timer sequencer: keypad entry, counter load, 1 s tick generation, run/pause/done control.
// Optional done beep with auto-return to IDLE is built when MICROWAVE_CTRL_BEEP_EN is defined.
module microwave_timer_ctrl #(
    parameter int TICK_DIV    = 50000000,
    parameter int BEEP_CYCLES = 25000000
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        start,
    input  logic        stop,
    input  logic        door_closed,
    input  logic [2:0]  cnt_zero,
    output logic        loadn,
    output logic        enable,
    output logic [11:0] entry,
    output logic        mag_on,
    output logic        done,
`ifdef MICROWAVE_CTRL_BEEP_EN
    output logic        beep,
`endif
    output logic [2:0]  state_out
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] C_PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] C_PRE_ONE  = PW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_PAUSE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    if (TICK_DIV < 2 || BEEP_CYCLES < 1) begin : g_bad_params
        $error("microwave_timer_ctrl: TICK_DIV must be >= 2 and BEEP_CYCLES >= 1");
    end

    state_t        r_state;
    state_t        w_state_nxt;
    logic [11:0]   r_entry;
    logic [11:0]   w_entry_nxt;
    logic [PW-1:0] r_prescaler;
    logic [PW-1:0] w_presc_nxt;
    logic          r_loadn;
    logic          r_enable;
    logic          w_enable_nxt;
    logic          r_mag_on;
    logic          r_done;
    logic          w_key_ok;
    logic          w_start_ok;

`ifdef MICROWAVE_CTRL_BEEP_EN
    localparam int BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
    localparam logic [BW-1:0] C_BEEP_LAST = BW'(BEEP_CYCLES - 1);
    localparam logic [BW-1:0] C_BEEP_ONE  = BW'(1);

    logic [BW-1:0] r_beep_cnt;
    logic [BW-1:0] w_beep_cnt_nxt;
    logic          r_beep;
`endif

    assign w_key_ok   = key_valid && (key_digit <= 4'd9);
    // Start needs a closed door, a non-zero time and a legal seconds-tens digit.
    assign w_start_ok = start && door_closed && (r_entry != 12'h000) && (r_entry[7:4] <= 4'd5);

    // Next-state, entry shift register, prescaler and tick decision.
    always_comb begin
        w_state_nxt  = r_state;
        w_entry_nxt  = r_entry;
        w_presc_nxt  = r_prescaler;
        w_enable_nxt = 1'b0;
`ifdef MICROWAVE_CTRL_BEEP_EN
        w_beep_cnt_nxt = (r_state == S_DONE) ? r_beep_cnt : {BW{1'b0}};
`endif
        case (r_state)
            S_IDLE: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_key_ok) begin
                    w_entry_nxt = {r_entry[7:0], key_digit};
                    w_state_nxt = S_ENTRY;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ENTRY: begin
                if (stop) begin
                    w_entry_nxt = 12'h000;
                    w_state_nxt = S_IDLE;
                end else if (w_start_ok) begin
                    w_state_nxt = S_LOAD;
                end else if (w_key_ok) begin
                    w_entry_nxt = {r_entry[7:0], key_digit};
                end else begin
                    w_state_nxt = S_ENTRY;
                end
            end
            S_LOAD: begin
                w_presc_nxt = {PW{1'b0}};
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (stop || !door_closed) begin
                    w_state_nxt = S_PAUSE;
                end else if (r_prescaler == C_PRE_LAST) begin
                    w_presc_nxt = {PW{1'b0}};
                    // All digits already zero: finish instead of ticking past 0:00.
                    if (cnt_zero == 3'b111) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_enable_nxt = 1'b1;
                    end
                end else begin
                    w_presc_nxt = r_prescaler + C_PRE_ONE;
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    w_entry_nxt = 12'h000;
                    w_state_nxt = S_IDLE;
                end else if (start && door_closed) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_PAUSE;
                end
            end
            S_DONE: begin
                if (start || stop || key_valid) begin
                    w_entry_nxt = 12'h000;
                    w_state_nxt = S_IDLE;
                end else begin
`ifdef MICROWAVE_CTRL_BEEP_EN
                    if (r_beep_cnt == C_BEEP_LAST) begin
                        w_entry_nxt = 12'h000;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_beep_cnt_nxt = r_beep_cnt + C_BEEP_ONE;
                    end
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end
            default: begin
                w_entry_nxt = 12'h000;
                w_presc_nxt = {PW{1'b0}};
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, data and registered outputs; outputs are decoded from the next state.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state     <= S_IDLE;
            r_entry     <= 12'h000;
            r_prescaler <= {PW{1'b0}};
            r_loadn     <= 1'b1;
            r_enable    <= 1'b0;
            r_mag_on    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_entry     <= w_entry_nxt;
            r_prescaler <= w_presc_nxt;
            r_loadn     <= (w_state_nxt != S_LOAD);
            r_enable    <= w_enable_nxt;
            r_mag_on    <= (w_state_nxt == S_RUN);
            r_done      <= (w_state_nxt == S_DONE);
        end
    end

`ifdef MICROWAVE_CTRL_BEEP_EN
    // Beep duration counter and beep output.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_beep_cnt <= {BW{1'b0}};
            r_beep     <= 1'b0;
        end else begin
            r_beep_cnt <= w_beep_cnt_nxt;
            r_beep     <= (w_state_nxt == S_DONE);
        end
    end

    assign beep = r_beep;
`endif

    assign loadn     = r_loadn;
    assign enable    = r_enable;
    assign entry     = r_entry;
    assign mag_on    = r_mag_on;
    assign done      = r_done;
    assign state_out = r_state;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Scoreboard bench for microwave_timer_ctrl (TICK_DIV=4, BEEP_CYCLES=6) with a BCD counter-chain model.
module tb_microwave_timer_ctrl;

    localparam int TICK_DIV    = 4;
    localparam int BEEP_CYCLES = 6;
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ENTRY = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] RUN   = 3'd3;
    localparam logic [2:0] PAUSE = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic        clock;
    logic        clear;
    logic        key_valid;
    logic [3:0]  key_digit;
    logic        start;
    logic        stop;
    logic        door_closed;
    logic [2:0]  cnt_zero;
    logic        loadn;
    logic        enable;
    logic [11:0] entry;
    logic        mag_on;
    logic        done;
    logic [2:0]  state_out;
`ifdef MICROWAVE_CTRL_BEEP_EN
    logic        beep;
`endif

    typedef struct {
        int          id;
        logic [2:0]  st;
        logic [11:0] ent;
        logic        ld;
        logic        en;
        logic        mg;
        logic        dn;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_vec    = 0;
    event ev_sample;

    logic [3:0] m_min, m_tens, m_ones;

    microwave_timer_ctrl #(
        .TICK_DIV(TICK_DIV),
        .BEEP_CYCLES(BEEP_CYCLES)
    ) dut (
        .clock(clock),
        .clear(clear),
        .key_valid(key_valid),
        .key_digit(key_digit),
        .start(start),
        .stop(stop),
        .door_closed(door_closed),
        .cnt_zero(cnt_zero),
        .loadn(loadn),
        .enable(enable),
        .entry(entry),
        .mag_on(mag_on),
        .done(done),
`ifdef MICROWAVE_CTRL_BEEP_EN
        .beep(beep),
`endif
        .state_out(state_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model of the cascaded BCD down-counters (min, sec-tens, sec-ones).
    always @(posedge clock) begin
        if (clear) begin
            m_min <= 4'd0; m_tens <= 4'd0; m_ones <= 4'd0;
        end else if (!loadn) begin
            m_min <= entry[11:8]; m_tens <= entry[7:4]; m_ones <= entry[3:0];
        end else if (enable) begin
            if (m_ones != 4'd0) begin
                m_ones <= m_ones - 4'd1;
            end else begin
                m_ones <= 4'd9;
                if (m_tens != 4'd0) begin
                    m_tens <= m_tens - 4'd1;
                end else begin
                    m_tens <= 4'd5;
                    m_min  <= m_min - 4'd1;
                end
            end
        end
    end
    assign cnt_zero = {m_min == 4'd0, m_tens == 4'd0, m_ones == 4'd0};

    task automatic check_vec(input exp_t e);
        logic ok;
        ok = (state_out === e.st) && (entry === e.ent) && (loadn === e.ld) &&
             (enable === e.en) && (mag_on === e.mg) && (done === e.dn);
`ifdef MICROWAVE_CTRL_BEEP_EN
        ok = ok && (beep === e.dn);
`endif
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL vec%0d: got st=%0d entry=%h loadn=%b en=%b mag=%b done=%b, expected st=%0d entry=%h loadn=%b en=%b mag=%b done=%b",
                      e.id, state_out, entry, loadn, enable, mag_on, done, e.st, e.ent, e.ld, e.en, e.mg, e.dn);
    endtask

    // Monitor: compares on every negedge, or immediately when asked for asynchronous checks.
    initial begin
        forever begin
            @(negedge clock or ev_sample);
            if (sb_q.size() > 0) check_vec(sb_q.pop_front());
        end
    end

    function automatic exp_t mk(input logic [2:0] s, input logic [11:0] e, input logic l,
                                input logic n, input logic m, input logic d);
        exp_t x;
        x.id = n_vec; x.st = s; x.ent = e; x.ld = l; x.en = n; x.mg = m; x.dn = d;
        return x;
    endfunction

    task automatic tick(input logic kv, input logic [3:0] kd, input logic st, input logic sp, input logic dc,
                        input logic [2:0] xs, input logic [11:0] xe, input logic xl,
                        input logic xn, input logic xm, input logic xd);
        key_valid = kv; key_digit = kd; start = st; stop = sp; door_closed = dc;
        @(posedge clock);
        sb_q.push_back(mk(xs, xe, xl, xn, xm, xd));
        n_vec++;
        @(negedge clock);
        #1;
    endtask

    task automatic snap(input logic [2:0] xs, input logic [11:0] xe, input logic xl,
                        input logic xn, input logic xm, input logic xd);
        sb_q.push_back(mk(xs, xe, xl, xn, xm, xd));
        n_vec++;
        ->ev_sample;
        #1;
    endtask

    task automatic key(input logic [3:0] d, input logic [2:0] xs, input logic [11:0] xe);
        tick(1'b1, d, 1'b0, 1'b0, 1'b1, xs, xe, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        clear = 1'b1; key_valid = 1'b0; key_digit = 4'd0; start = 1'b0; stop = 1'b0; door_closed = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        snap(IDLE, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        clear = 1'b0;
        tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, IDLE, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);

        // Key entry and shifting
        key(4'd1, ENTRY, 12'h001);
        key(4'd3, ENTRY, 12'h013);
        key(4'd0, ENTRY, 12'h130);
        key(4'hA, ENTRY, 12'h130);
        key(4'd5, ENTRY, 12'h305);
        tick(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, IDLE, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);

        // Rejected starts: bad tens digit, zero time, door open
        key(4'd0, ENTRY, 12'h000);
        key(4'd7, ENTRY, 12'h007);
        key(4'd0, ENTRY, 12'h070);
        tick(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, ENTRY, 12'h070, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, IDLE, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, IDLE, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        key(4'd1, ENTRY, 12'h001);
        tick(1'b0, 4'd0, 1'b1, 1'b1, 1'b1, IDLE, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        key(4'd1, ENTRY, 12'h001);
        key(4'd2, ENTRY, 12'h012);
        tick(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, ENTRY, 12'h012, 1'b1, 1'b0, 1'b0, 1'b0);

        // Accepted start: one LOAD cycle, then RUN with an enable every 4th cycle
        tick(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, LOAD, 12'h012, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, RUN, 12'h012, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 10; i++)
            tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, RUN, 12'h012, 1'b1, (i == 4 || i == 8), 1'b1, 1'b0);

        // Door opens at prescaler=2, then close and resume
        tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, PAUSE, 12'h012, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 4'd3, 1'b0, 1'b0, 1'b1, PAUSE, 12'h012, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, RUN, 12'h012, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, RUN, 12'h012, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, RUN, 12'h012, 1'b1, 1'b1, 1'b1, 1'b0);

        // Asynchronous clear mid-RUN while enable is high
        clear = 1'b1;
        #1;
        snap(IDLE, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, IDLE, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        clear = 1'b0;

        // Run 0:02 to completion
        key(4'd2, ENTRY, 12'h002);
        tick(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, LOAD, 12'h002, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, RUN, 12'h002, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 11; i++)
            tick(1'b1, 4'd4, 1'b0, 1'b0, 1'b1, RUN, 12'h002, 1'b1, (i == 4 || i == 8), 1'b1, 1'b0);
        tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, DONE, 12'h002, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++)
            tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, DONE, 12'h002, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef MICROWAVE_CTRL_BEEP_EN
        tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, IDLE, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
`else
        tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, DONE, 12'h002, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 4'd4, 1'b0, 1'b0, 1'b1, IDLE, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

        // Stop in RUN pauses, stop in PAUSE cancels
        key(4'd1, ENTRY, 12'h001);
        tick(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, LOAD, 12'h001, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, RUN, 12'h001, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 4'd0, 1'b1, 1'b1, 1'b1, PAUSE, 12'h001, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 4'd0, 1'b1, 1'b1, 1'b1, IDLE, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);

        repeat (2) @(negedge clock);
        #1;
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
